// File: rtl/k732_hls_fir_filter_ip.sv
// Boxcar FIR filter: output is the wrapping sum of the N most recent samples,
// where N is derived each cycle from fir_time and clamped to 1..32.
module k732_hls_fir_filter_ip (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic [31:0] input_r,
  input  logic [31:0] fir_time,
  output logic [31:0] output_r,
  output logic        result_valid
);

  localparam int unsigned MaxTaps = 32;

  logic [31:0] d_q [MaxTaps];
  logic [5:0]  cnt_q;
  logic [5:0]  n_eff;
  logic [31:0] sum;
  logic [31:0] output_q;
  logic        valid_q;

  // Clamp the requested tap count: zero means a single tap, anything above 32 uses all taps.
  always_comb begin
    n_eff = 6'd1;
    if (fir_time == 32'd0) begin
      n_eff = 6'd1;
    end else if (fir_time > 32'd32) begin
      n_eff = 6'd32;
    end else begin
      n_eff = fir_time[5:0];
    end
  end

  // Sum the newest n_eff taps of the delay line; overflow wraps modulo 2^32.
  always_comb begin
    sum = 32'd0;
    for (int k = 0; k < MaxTaps; k++) begin
      if (6'(k) < n_eff) begin
        sum = sum + d_q[k];
      end
    end
  end

  // Delay line shift, saturating sample counter and registered result.
  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      for (int k = 0; k < MaxTaps; k++) begin
        d_q[k] <= 32'd0;
      end
      cnt_q    <= 6'd0;
      output_q <= 32'd0;
      valid_q  <= 1'b0;
    end else begin
      d_q[0] <= input_r;
      for (int k = 1; k < MaxTaps; k++) begin
        d_q[k] <= d_q[k-1];
      end
      if (cnt_q != 6'd32) begin
        cnt_q <= cnt_q + 6'd1;
      end
      output_q <= sum;
      // Valid only once the window is fully populated with post-reset samples.
      valid_q  <= (cnt_q >= n_eff);
    end
  end

  assign output_r     = output_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_k732_hls_fir_filter_ip.sv
// Scoreboard bench for the boxcar FIR: stimulus pushes hand-derived expectations,
// a monitor pops one entry per clock edge and compares the registered outputs.
module tb_k732_hls_fir_filter_ip;

  logic        ap_clk;
  logic        ap_rst;
  logic [31:0] input_r;
  logic [31:0] fir_time;
  logic [31:0] output_r;
  logic        result_valid;

  typedef struct {
    logic [31:0] data;
    logic        valid;
    int          test_id;
    int          edge_no;
  } exp_t;

  exp_t exp_q [$];
  int   n_compared;
  int   n_mismatched;

  k732_hls_fir_filter_ip dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .input_r      (input_r),
    .fir_time     (fir_time),
    .output_r     (output_r),
    .result_valid (result_valid)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Monitor: one expectation per active edge, sampled 1 time unit after the edge.
  always @(posedge ap_clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_compared++;
      if (result_valid !== e.valid) begin
        n_mismatched++;
        $display("FAIL valid test%0d edge%0d: got %0b expected %0b",
                 e.test_id, e.edge_no, result_valid, e.valid);
      end
      n_compared++;
      if (output_r !== e.data) begin
        n_mismatched++;
        $display("FAIL data test%0d edge%0d: got 0x%08h expected 0x%08h",
                 e.test_id, e.edge_no, output_r, e.data);
      end
    end
  end

  task automatic check_zero(input int test_id);
    n_compared++;
    if (output_r !== 32'd0 || result_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_zero test%0d: got data 0x%08h valid %0b expected 0 / 0",
               test_id, output_r, result_valid);
    end
  endtask

  // Assert reset between edges, verify outputs clear immediately, then release mid-phase.
  task automatic do_reset(input int test_id);
    @(posedge ap_clk);
    #2;
    ap_rst = 1'b0;
    #1;
    check_zero(test_id);
    @(posedge ap_clk);
    #2;
    check_zero(test_id);
    ap_rst = 1'b1;
  endtask

  // Drive one sample ahead of the next edge and queue what that edge must produce.
  task automatic step(input logic [31:0] din, input logic [31:0] ft, input logic [31:0] exp_data,
                      input logic exp_valid, input int test_id, input int edge_no);
    exp_t e;
    @(negedge ap_clk);
    input_r  = din;
    fir_time = ft;
    e.data    = exp_data;
    e.valid   = exp_valid;
    e.test_id = test_id;
    e.edge_no = edge_no;
    exp_q.push_back(e);
  endtask

  // Constant input c with effective taps n: edge e gives c*min(e-1,n), valid once e-1 >= n.
  task automatic run_const(input logic [31:0] c, input logic [31:0] ft, input int n,
                           input int first_edge, input int last_edge, input int test_id);
    for (int e = first_edge; e <= last_edge; e++) begin
      int filled;
      filled = (e - 1 < n) ? e - 1 : n;
      step(c, ft, c * 32'(filled), (e - 1) >= n, test_id, e);
    end
  endtask

  initial begin
    logic [31:0] odd_in  [4];
    logic [31:0] odd_exp [4];
    n_compared   = 0;
    n_mismatched = 0;
    ap_rst   = 1'b0;
    input_r  = 32'd0;
    fir_time = 32'd0;

    // Test 1: constant 5, 20 taps -> 100 from edge 21 onward.
    do_reset(1);
    run_const(32'd5, 32'd20, 20, 1, 26, 1);

    // Test 2: ramp 1,2,3,... with 4 taps -> 10, 14, 18, 22 once valid.
    do_reset(2);
    for (int e = 1; e <= 8; e++) begin
      int s;
      s = 0;
      for (int j = e - 4; j < e; j++) begin
        if (j >= 1) s += j;
      end
      step(32'(e), 32'd4, 32'(s), e >= 5, 2, e);
    end

    // Test 3: fir_time 0 behaves as a single tap (one-cycle delay).
    do_reset(3);
    odd_in[0] = 32'd7;  odd_in[1] = 32'd9;  odd_in[2] = 32'd11; odd_in[3] = 32'd13;
    odd_exp[0] = 32'd0; odd_exp[1] = 32'd7; odd_exp[2] = 32'd9;  odd_exp[3] = 32'd11;
    for (int e = 1; e <= 4; e++) begin
      step(odd_in[e-1], 32'd0, odd_exp[e-1], e >= 2, 3, e);
    end

    // Test 4: fir_time 100 clamps to 32 taps.
    do_reset(4);
    run_const(32'd1, 32'd100, 32, 1, 36, 4);

    // Test 5: all-ones input with 2 taps wraps to 0xFFFFFFFE.
    do_reset(5);
    run_const(32'hFFFF_FFFF, 32'd2, 2, 1, 5, 5);

    // Test 6: grow taps 4 -> 8 at cnt 6 drops valid, then shrink to 2 takes effect at once.
    do_reset(6);
    run_const(32'd3, 32'd4, 4, 1, 6, 6);
    run_const(32'd3, 32'd8, 8, 7, 10, 6);
    run_const(32'd3, 32'd2, 2, 11, 13, 6);

    // Test 7: mid-stream reset discards history; valid returns after N+1 edges.
    do_reset(7);
    run_const(32'd2, 32'd3, 3, 1, 6, 7);
    do_reset(7);
    run_const(32'd2, 32'd3, 3, 1, 6, 7);

    repeat (3) @(posedge ap_clk);
    #2;
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/k732_hls_fir_filter_ip.md
K732_HLS_FIR_FILTER_IP -- requirements
Module: k732_hls_fir_filter_ip

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-002 ap_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 ap_rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-004 input_r  input  32  unsigned sample; sampled every rising edge.
REQ-005 fir_time  input  32  unsigned requested tap count; sampled every rising edge.
REQ-006 output_r  output  32  filtered result, registered.
REQ-007 result_valid  output  1  high when output_r holds a full-window result, registered.
REQ-008 SHALL contain no parameters; maximum tap depth MAXT = 32 is fixed.

Function
REQ-009 SHALL be a boxcar FIR filter: all coefficients = 1; output is the sum of the N most recent captured samples.
REQ-010 Effective tap count: N = 1 if fir_time = 0; N = 32 if fir_time > 32; otherwise N = fir_time.
REQ-011 Delay line: 32 x 32-bit registers d[0..31]; each edge: d[0] <= input_r, d[k] <= d[k-1] for k = 1..31.
REQ-012 Sample counter cnt (6 bits) SHALL increment each edge and saturate at 32.
REQ-013 Each edge: output_r <= sum of d[k] for k < N, using pre-edge d values.
REQ-014 Each edge: result_valid <= (pre-edge cnt >= N).
REQ-015 Arithmetic SHALL be unsigned, modulo 2^32; overflow wraps silently; no saturation.
REQ-016 Latency: a sample on input_r at edge t first appears in output_r at edge t+1.
REQ-017 result_valid first rises at edge N+1 after reset release.
REQ-018 fir_time SHALL be re-evaluated every cycle; a change takes effect at the next edge.
REQ-019 Increasing N above cnt SHALL drop result_valid until cnt reaches the new N; decreasing N takes effect immediately.
REQ-020 No input handshake: every edge is a sample; the design has no backpressure and no ready signal.
REQ-021 result_valid, once high, SHALL stay high while N <= cnt; cnt never decrements except on reset.

Reset
REQ-022 While ap_rst = 0 (asynchronously, independent of ap_clk): d[*] = 0, cnt = 0, output_r = 0, result_valid = 0.
REQ-023 Reset asserted mid-operation SHALL discard all history; after release, behaviour is identical to power-up.
REQ-024 The first edge with ap_rst = 1 SHALL capture input_r into d[0] and set cnt = 1.

Verification
REQ-025 Constant input_r = 5, fir_time = 20: result_valid low through edge 20 after release; at edge 21 result_valid = 1 and output_r = 100, stable thereafter.
REQ-026 Ramp input_r = 1, 2, 3, ... (one value per edge), fir_time = 4: first valid output_r = 10 (1+2+3+4), followed by 14, 18, 22.
REQ-027 fir_time = 0 and input_r = 7, 9: output_r equals the previous cycle's input (7, then 9), valid from edge 2; fir_time = 100 behaves as N = 32.
REQ-028 Wrap: input_r = 0xFFFFFFFF constant, fir_time = 2: valid output_r = 0xFFFFFFFE.
REQ-029 Change fir_time from 4 to 8 while cnt = 6: result_valid drops the next edge and returns once cnt >= 8.
REQ-030 Assert ap_rst mid-stream between clock edges: output_r and result_valid go to 0 immediately; after release, valid reappears after N+1 edges.
